// File: rtl/softmax_normalizer.sv
// Softmax normalizer: prob_i = exp_i / sum, via a bit-serial restoring reciprocal
// (floor(2^30 / S)) followed by LANES-wide scaling of the latched exp vector.
module softmax_normalizer #(
  parameter int D_MODEL = 64,
  parameter int IN_W    = 16,
  parameter int SUM_W   = 24,
  parameter int LANES   = 8,
  parameter int RECIP_W = 31
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SUM_W-1:0]        sum_in,
  input  logic                    sum_valid,
  input  logic [D_MODEL*IN_W-1:0] exp_values_in,
  output logic [D_MODEL*IN_W-1:0] prob_out,
  output logic                    prob_valid,
  output logic                    busy,
  output logic                    div_err,
  output logic                    overrun
);

  localparam int BLKS   = D_MODEL / LANES;
  localparam int BLK_W  = (BLKS > 1) ? $clog2(BLKS) : 1;
  localparam int CNT_W  = $clog2(RECIP_W);
  localparam int LW     = LANES * IN_W;
  localparam int PROD_W = IN_W + RECIP_W;
  localparam int SHIFT  = 20;
  localparam int P_W    = PROD_W - SHIFT;
  localparam logic [P_W-1:0]  P_MAX   = P_W'({1'b0, {(IN_W-1){1'b1}}});
  localparam logic [IN_W-1:0] P_SAT   = {1'b0, {(IN_W-1){1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_SCALE, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [SUM_W-1:0]   r_sum;
  logic [SUM_W:0]     r_rem;
  logic [RECIP_W-1:0] r_recip;
  logic [CNT_W-1:0]   r_cnt;
  logic [BLK_W-1:0]   r_blk;
  logic               r_div_err;
  logic               r_overrun;
  logic [LW-1:0]      r_exp_blk  [BLKS];
  logic [LW-1:0]      r_prob_blk [BLKS];

  logic               w_accept;
  logic               w_sum_bad;
  logic               w_dbit;
  logic [SUM_W+1:0]   w_trial;
  logic               w_ge;
  logic [LW-1:0]      w_blk_exp;
  logic [LW-1:0]      w_blk_prob;

  assign w_accept  = (r_state == S_IDLE) && sum_valid;
  assign w_sum_bad = (sum_in == '0) || sum_in[SUM_W-1];

  // Dividend 2^30 contributes a single 1 bit, shifted in on the first iteration.
  assign w_dbit  = (r_cnt == CNT_W'(RECIP_W - 1));
  assign w_trial = {r_rem, w_dbit};
  assign w_ge    = (w_trial >= {2'b00, r_sum});

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_sum_bad ? S_SCALE : S_DIV;
      S_DIV:   if (r_cnt == '0) w_next = S_SCALE;
      S_SCALE: if (r_blk == BLK_W'(BLKS - 1)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state != S_IDLE);
    prob_valid = (r_state == S_DONE);
  end

  assign w_blk_exp = r_exp_blk[r_blk];

  always_comb begin
    logic [IN_W-1:0] v_e;
    logic [P_W-1:0]  v_p;
    w_blk_prob = '0;
    v_e        = '0;
    v_p        = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      v_e = w_blk_exp[j*IN_W +: IN_W];
      v_p = P_W'(({{RECIP_W{1'b0}}, v_e} * {{IN_W{1'b0}}, r_recip}) >> SHIFT);
      if (r_div_err || v_e[IN_W-1]) w_blk_prob[j*IN_W +: IN_W] = '0;
      else if (v_p > P_MAX)         w_blk_prob[j*IN_W +: IN_W] = P_SAT;
      else                          w_blk_prob[j*IN_W +: IN_W] = v_p[IN_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum     <= '0;
      r_rem     <= '0;
      r_recip   <= '0;
      r_cnt     <= '0;
      r_blk     <= '0;
      r_div_err <= 1'b0;
      r_overrun <= 1'b0;
      for (int unsigned b = 0; b < BLKS; b++) begin
        r_exp_blk[b]  <= '0;
        r_prob_blk[b] <= '0;
      end
    end else begin
      r_overrun <= sum_valid && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sum     <= sum_in;
            r_div_err <= w_sum_bad;
            r_recip   <= '0;
            r_rem     <= '0;
            r_cnt     <= CNT_W'(RECIP_W - 1);
            r_blk     <= '0;
            for (int unsigned b = 0; b < BLKS; b++)
              r_exp_blk[b] <= exp_values_in[b*LW +: LW];
          end
        end
        S_DIV: begin
          r_rem   <= w_ge ? (SUM_W+1)'(w_trial - {2'b00, r_sum}) : (SUM_W+1)'(w_trial);
          r_recip <= {r_recip[RECIP_W-2:0], w_ge};
          r_cnt   <= r_cnt - 1'b1;
        end
        S_SCALE: begin
          r_prob_blk[r_blk] <= w_blk_prob;
          r_blk             <= r_blk + 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar b = 0; b < BLKS; b++) begin : g_out
    assign prob_out[b*LW +: LW] = r_prob_blk[b];
  end

  assign div_err = r_div_err;
  assign overrun = r_overrun;

endmodule
